menu_overlay: RTL and testbench

- Parametrised menu compositor for the VGA front end. It composites an upscaled ROM image window with a selectable arrow cursor over N menu items.
- Contains a browse/locked selection state machine with edge-detected buttons, and frame-synchronous cursor update (no tearing).
- Pipelined ROM address generation aligned to a configurable ROM read latency.
- Sits between the timing generator (x/y), the image block-ROM and the top-level page mux, which consumes sel_idx/sel_valid.

---
 rtl/menu_overlay.sv | 148 ++++++++++++++
 tb/tb_menu_overlay.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/menu_overlay.sv
// Menu compositor: scaled ROM image window plus a frame-synchronous arrow cursor.
// It also contains a browse/locked selection FSM driven by edge-detected buttons.
module menu_overlay #(
   parameter int         H_LEFT      = 184,
   parameter int         V_TOP       = 29,
   parameter int         IMG_W       = 200,
   parameter int         IMG_H       = 150,
   parameter int         SCALE_SHIFT = 2,
   parameter int         N_ITEMS     = 3,
   parameter int         ARROW_X     = 300,
   parameter int         ITEM_Y0     = 150,
   parameter int         ITEM_PITCH  = 160,
   parameter int         ARROW_LEN   = 16,
   parameter logic [11:0] ARROW_RGB  = 12'h000,
   parameter int         ROM_LAT     = 1,
   parameter int         ADDR_W      = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [10:0]                  x,
   input  logic [9:0]                   y,
   input  logic                         up,
   input  logic                         down,
   input  logic                         enter,
   input  logic                         back,
   input  logic                         arrow_en,
   input  logic [11:0]                  rom_data,
   output logic [ADDR_W-1:0]            rom_addr,
   output logic [11:0]                  prgb,
   output logic [$clog2(N_ITEMS)-1:0]   sel_idx,
   output logic                         sel_valid,
   output logic                         locked
);

   localparam int IDX_W = $clog2(N_ITEMS);
   localparam logic [10:0]      X_LO    = 11'(H_LEFT);
   localparam logic [10:0]      X_HI    = 11'(H_LEFT + (IMG_W << SCALE_SHIFT));
   localparam logic [9:0]       Y_LO    = 10'(V_TOP);
   localparam logic [9:0]       Y_HI    = 10'(V_TOP + (IMG_H << SCALE_SHIFT));
   localparam logic [10:0]      AX      = 11'(ARROW_X);
   localparam logic [10:0]      AX_END  = 11'(ARROW_X + ARROW_LEN);
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_ITEMS - 1);

   typedef enum logic {BROWSE, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cursor, cursor_d, cursor_disp;
   logic              sel_fire;
   logic              up_q, down_q, enter_q, back_q;
   logic              up_r, down_r, enter_r, back_r;

   assign up_r    = up    & ~up_q;
   assign down_r  = down  & ~down_q;
   assign enter_r = enter & ~enter_q;
   assign back_r  = back  & ~back_q;
   assign locked  = (state_q == LOCKED);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      cursor_d = cursor;
      sel_fire = 1'b0;
      case (state_q)
         BROWSE: begin
            if (enter_r) begin
               sel_fire = 1'b1;
               state_d  = LOCKED;
            end else if (up_r && !down_r) begin
               cursor_d = (cursor == '0) ? LAST : cursor - 1'b1;
            end else if (down_r && !up_r) begin
               cursor_d = (cursor == LAST) ? '0 : cursor + 1'b1;
            end
         end
         LOCKED: begin
            if (back_r) state_d = BROWSE;
         end
         default: state_d = BROWSE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BROWSE;
         cursor      <= '0;
         cursor_disp <= '0;
         sel_idx     <= '0;
         sel_valid   <= 1'b0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
         enter_q     <= 1'b0;
         back_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cursor    <= cursor_d;
         sel_valid <= sel_fire;
         if (sel_fire) sel_idx <= cursor;
         up_q      <= up;
         down_q    <= down;
         enter_q   <= enter;
         back_q    <= back;
         // Cursor moves only at frame start so a frame never shows two arrows.
         if (x == '0 && y == '0) cursor_disp <= cursor;
      end
   end

   logic [9:0]        ay;
   logic              arrow_hit, win;
   logic [10:0]       dx;
   logic [9:0]        dy;
   logic [ADDR_W-1:0] addr_d;

   assign ay     = 10'(ITEM_Y0 + int'(cursor_disp) * ITEM_PITCH);
   assign win    = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
   assign dx     = x - X_LO;
   assign dy     = y - Y_LO;
   assign addr_d = ADDR_W'(dy >> SCALE_SHIFT) * ADDR_W'(IMG_W) + ADDR_W'(dx >> SCALE_SHIFT);

   // Shaft along row ay plus a 4-pixel arrowhead opening to the right of the tip.
   always_comb begin
      arrow_hit = (y == ay) && (x >= AX) && (x <= AX_END);
      for (int k = 1; k <= 4; k++) begin
         if (x == AX + 11'(k) && (y == ay + 10'(k) || y == ay - 10'(k))) arrow_hit = 1'b1;
      end
   end

   logic [ROM_LAT:0] win_pipe, arrow_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr   <= '0;
         win_pipe   <= '0;
         arrow_pipe <= '0;
         prgb       <= '0;
      end else begin
         rom_addr   <= win ? addr_d : '0;
         win_pipe   <= {win_pipe[ROM_LAT-1:0], win};
         arrow_pipe <= {arrow_pipe[ROM_LAT-1:0], arrow_hit};
         if (!win_pipe[ROM_LAT])
            prgb <= '0;
         else if (arrow_pipe[ROM_LAT] && arrow_en && !locked)
            prgb <= ARROW_RGB;
         else
            prgb <= rom_data;
      end
   end

endmodule

// File: tb/tb_menu_overlay.sv
// Directed bench for menu_overlay: scoreboard queues hold expected rom_addr/prgb
// values pushed at drive time and are popped when each output becomes due.
module tb_menu_overlay;

   logic        clk, rst;
   logic [10:0] x;
   logic [9:0]  y;
   logic        up, down, enter, back, arrow_en;
   logic [11:0] rom_data;
   logic [14:0] rom_addr;
   logic [11:0] prgb;
   logic [1:0]  sel_idx;
   logic        sel_valid, locked;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   int          addr_due[$];
   logic [31:0] addr_exp[$];
   string       addr_tag[$];
   int          pix_due[$];
   logic [31:0] pix_exp[$];
   string       pix_tag[$];

   menu_overlay dut (
      .clk(clk), .rst(rst), .x(x), .y(y),
      .up(up), .down(down), .enter(enter), .back(back),
      .arrow_en(arrow_en), .rom_data(rom_data), .rom_addr(rom_addr),
      .prgb(prgb), .sel_idx(sel_idx), .sel_valid(sel_valid), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle ROM model; address 0 returns a distinct colour.
   always @(posedge clk) rom_data <= (rom_addr == 15'd0) ? 12'h5A5 : 12'hABC;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (addr_due.size() > 0 && addr_due[0] <= cyc) begin
            void'(addr_due.pop_front());
            check(addr_tag.pop_front(), 32'(rom_addr), addr_exp.pop_front());
         end
         if (pix_due.size() > 0 && pix_due[0] <= cyc) begin
            void'(pix_due.pop_front());
            check(pix_tag.pop_front(), 32'(prgb), pix_exp.pop_front());
         end
      end
   end

   // exp_addr < 0 means the address is not checked for this pixel.
   task automatic pix(input int xx, input int yy, input logic [11:0] exp_rgb,
                      input int exp_addr, input string tag);
      @(negedge clk);
      x = 11'(xx);
      y = 10'(yy);
      pix_due.push_back(cyc + 3);
      pix_exp.push_back(32'(exp_rgb));
      pix_tag.push_back({tag, "_prgb"});
      if (exp_addr >= 0) begin
         addr_due.push_back(cyc + 1);
         addr_exp.push_back(32'(exp_addr));
         addr_tag.push_back({tag, "_addr"});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         x = 11'd1000;
         y = 10'd700;
      end
   endtask

   task automatic press(input logic u, input logic d, input logic e, input logic b);
      @(negedge clk);
      up = u; down = d; enter = e; back = b;
      @(negedge clk);
      up = 1'b0; down = 1'b0; enter = 1'b0; back = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      x = 11'd1000; y = 10'd700;
      up = 1'b0; down = 1'b0; enter = 1'b0; back = 1'b0; arrow_en = 1'b1;
      #1;
      check("rst_prgb", 32'(prgb), 32'h0);
      check("rst_addr", 32'(rom_addr), 32'h0);
      check("rst_sel_valid", 32'(sel_valid), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_sel_idx", 32'(sel_idx), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Address mapping and window bounds
      pix(184, 29,  12'h5A5, 0,     "win_origin");
      pix(188, 33,  12'hABC, 201,   "texel_1_1");
      pix(983, 628, 12'hABC, 29999, "win_last");
      pix(984, 100, 12'h000, 0,     "win_right_out");
      pix(500, 629, 12'h000, 0,     "win_bottom_out");
      pix(183, 100, 12'h000, 0,     "win_left_out");
      idle(4);

      // Arrow shape at item 0
      pix(300, 150, 12'h000, -1, "arrow_tip");
      pix(316, 150, 12'h000, -1, "arrow_shaft_end");
      pix(317, 150, 12'hABC, -1, "arrow_past_shaft");
      pix(303, 147, 12'h000, -1, "arrow_head_up");
      pix(304, 154, 12'h000, -1, "arrow_head_dn");
      pix(305, 145, 12'hABC, -1, "arrow_head_k5");
      pix(299, 150, 12'hABC, -1, "arrow_before_tip");
      idle(4);
      arrow_en = 1'b0;
      idle(1);
      pix(300, 150, 12'hABC, -1, "arrow_disabled");
      idle(4);
      arrow_en = 1'b1;
      idle(2);

      // Up wraps 0 -> 2; display waits for frame start
      press(1'b1, 1'b0, 1'b0, 1'b0);
      pix(300, 150, 12'h000, -1, "wrap_old_frame");
      pix(300, 470, 12'hABC, -1, "wrap_not_yet");
      pix(0, 0,     12'h000, -1, "frame_sync_a");
      pix(300, 470, 12'h000, -1, "wrap_new_frame");
      pix(300, 150, 12'hABC, -1, "wrap_old_gone");
      idle(4);

      // Down wraps 2 -> 0
      press(1'b0, 1'b1, 1'b0, 1'b0);
      pix(0, 0,     12'h000, -1, "frame_sync_b");
      pix(300, 150, 12'h000, -1, "down_wrap_item0");
      pix(300, 470, 12'hABC, -1, "down_wrap_item2_off");
      idle(4);

      // Up and down together: no move
      press(1'b1, 1'b1, 1'b0, 1'b0);
      pix(0, 0,     12'h000, -1, "frame_sync_c");
      pix(300, 150, 12'h000, -1, "updown_stay");
      pix(300, 310, 12'hABC, -1, "updown_item1_off");
      idle(4);

      // Back is ignored while browsing
      press(1'b0, 1'b0, 1'b0, 1'b1);
      check("browse_back_locked", 32'(locked), 32'h0);
      check("browse_back_valid", 32'(sel_valid), 32'h0);

      // Down to item 1, then enter+down together selects item 1
      press(1'b0, 1'b1, 1'b0, 1'b0);
      pix(0, 0,     12'h000, -1, "frame_sync_d");
      pix(300, 310, 12'h000, -1, "item1_drawn");
      idle(4);
      press(1'b0, 1'b1, 1'b1, 1'b0);
      check("sel_valid_pulse", 32'(sel_valid), 32'h1);
      check("sel_idx_1", 32'(sel_idx), 32'h1);
      check("locked_set", 32'(locked), 32'h1);
      @(negedge clk);
      check("sel_valid_drop", 32'(sel_valid), 32'h0);
      pix(0, 0,     12'h000, -1, "frame_sync_e");
      pix(300, 310, 12'hABC, -1, "locked_no_arrow");
      idle(4);

      // Locked: up/down/enter ignored
      press(1'b1, 1'b0, 1'b0, 1'b0);
      check("locked_up_valid", 32'(sel_valid), 32'h0);
      press(1'b0, 1'b1, 1'b0, 1'b0);
      check("locked_down_valid", 32'(sel_valid), 32'h0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      check("locked_enter_valid", 32'(sel_valid), 32'h0);
      check("locked_sel_idx", 32'(sel_idx), 32'h1);
      check("locked_still", 32'(locked), 32'h1);
      pix(0, 0,     12'h000, -1, "frame_sync_f");
      pix(300, 310, 12'hABC, -1, "locked_no_arrow2");
      pix(300, 150, 12'hABC, -1, "locked_no_arrow0");
      idle(4);

      // Back releases; arrow returns at the same item
      press(1'b0, 1'b0, 1'b0, 1'b1);
      check("back_unlock", 32'(locked), 32'h0);
      pix(0, 0,     12'h000, -1, "frame_sync_g");
      pix(300, 310, 12'h000, -1, "unlock_item1");
      pix(300, 150, 12'hABC, -1, "unlock_item0_off");
      pix(300, 470, 12'hABC, -1, "unlock_item2_off");
      idle(4);

      // Async reset mid-line with the pipeline full and the FSM locked
      press(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      x = 11'd400; y = 10'd200;
      repeat (4) @(negedge clk);
      check("pre_rst_prgb", 32'(prgb), 32'hABC);
      check("pre_rst_addr", 32'(rom_addr), 32'd8454);
      check("pre_rst_locked", 32'(locked), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("async_prgb", 32'(prgb), 32'h0);
      check("async_addr", 32'(rom_addr), 32'h0);
      check("async_sel_valid", 32'(sel_valid), 32'h0);
      check("async_locked", 32'(locked), 32'h0);
      check("async_sel_idx", 32'(sel_idx), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("refill_addr", 32'(rom_addr), 32'd8454);
      check("refill_c1", 32'(prgb), 32'h0);
      @(negedge clk);
      check("refill_c2", 32'(prgb), 32'h0);
      @(negedge clk);
      check("refill_c3", 32'(prgb), 32'hABC);

      idle(2);
      for (int i = 0; i < 10 && (pix_due.size() + addr_due.size()) > 0; i++) idle(1);
      check("scoreboard_drain", 32'(pix_due.size() + addr_due.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
